// File: rtl/regfile_write_arbiter.sv
// Two-port writeback arbiter for the integer register file: optional zero-sweep
// of x1..x31 after reset, then round-robin arbitration with a one-cycle registered write.
module regfile_write_arbiter #(
    parameter int REGISTER_WIDTH = 32,
    parameter bit INIT_ENABLE    = 1'b1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      req0_valid,
    output logic                      req0_ready,
    input  logic [4:0]                req0_addr,
    input  logic [REGISTER_WIDTH-1:0] req0_data,
    input  logic                      req1_valid,
    output logic                      req1_ready,
    input  logic [4:0]                req1_addr,
    input  logic [REGISTER_WIDTH-1:0] req1_data,
    output logic                      rf_we,
    output logic [4:0]                rf_addr,
    output logic [REGISTER_WIDTH-1:0] rf_wd,
    output logic                      grant_id,
    output logic                      init_done
);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t                      state_q;
    logic [4:0]                  cnt_q;
    logic                        ptr_q;
    logic                        rf_we_q;
    logic [4:0]                  rf_addr_q;
    logic [REGISTER_WIDTH-1:0]   rf_wd_q;
    logic                        grant_id_q;
    logic                        init_done_q;

    logic                        accept_en;
    logic                        sel_valid_d;
    logic                        sel_port_d;
    logic [4:0]                  sel_addr_d;
    logic [REGISTER_WIDTH-1:0]   sel_data_d;

    // init_done gates acceptance so the no-sweep build still waits one edge after reset
    assign accept_en = !reset && init_done_q && (state_q == ST_RUN);

    always_comb begin
        sel_valid_d = 1'b0;
        sel_port_d  = 1'b0;
        if (accept_en) begin
            if (req0_valid && req1_valid) begin
                sel_valid_d = 1'b1;
                sel_port_d  = ptr_q;
            end else if (req0_valid) begin
                sel_valid_d = 1'b1;
                sel_port_d  = 1'b0;
            end else if (req1_valid) begin
                sel_valid_d = 1'b1;
                sel_port_d  = 1'b1;
            end
        end
        sel_addr_d = sel_port_d ? req1_addr : req0_addr;
        sel_data_d = sel_port_d ? req1_data : req0_data;
    end

    assign req0_ready = sel_valid_d && !sel_port_d;
    assign req1_ready = sel_valid_d &&  sel_port_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= INIT_ENABLE ? ST_INIT : ST_RUN;
            cnt_q       <= 5'd1;
            ptr_q       <= 1'b0;
            rf_we_q     <= 1'b0;
            rf_addr_q   <= 5'd0;
            rf_wd_q     <= '0;
            grant_id_q  <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    rf_we_q   <= 1'b1;
                    rf_addr_q <= cnt_q;
                    rf_wd_q   <= '0;
                    cnt_q     <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_q     <= ST_RUN;
                        init_done_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    init_done_q <= 1'b1;
                    if (sel_valid_d) begin
                        // x0 is hardwired: complete the handshake but never write it
                        rf_we_q    <= (sel_addr_d != 5'd0);
                        rf_addr_q  <= sel_addr_d;
                        rf_wd_q    <= sel_data_d;
                        grant_id_q <= sel_port_d;
                        ptr_q      <= ~sel_port_d;
                    end else begin
                        rf_we_q <= 1'b0;
                    end
                end
                default: state_q <= ST_RUN;
            endcase
        end
    end

    assign rf_we     = rf_we_q;
    assign rf_addr   = rf_addr_q;
    assign rf_wd     = rf_wd_q;
    assign grant_id  = grant_id_q;
    assign init_done = init_done_q;

endmodule
